op_issue_encoder: RTL and testbench
===================================

Name: op_issue_encoder

Overview:
- Inverse of the opcode decoder CU: collects one-hot operation requests (8 lines, one per opcode slot) and encodes them into a 3-bit opcode plus enable strobe for the decoder/ALU.
- Issues one opcode at a time under a valid/ready handshake, with selectable round-robin or fixed-priority arbitration.
- Stalls on multi-cycle operations (MUL, DIV by default) until the execution unit signals done, with a timeout guard.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- MULTI_MASK, 8'b0000_1100, bit i set = opcode i is multi-cycle and must wait for exec_done (default: MUL=2, DIV=3).
- TIMEOUT, 64, max cycles in WAIT before abort; counter width = clog2(TIMEOUT+1).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- req, input, 8, request pulses; bit i requests opcode i (0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOVE, 5-7 reserved).
- opcode, output, 3, encoded opcode to decoder; registered.
- E, output, 1, decoder enable / valid; high only in ISSUE.
- ready, input, 1, downstream accepts opcode when E & ready.
- exec_done, input, 1, one-cycle pulse from execution unit ending a multi-cycle op.
- pending, output, 8, current pending-request vector.
- busy, output, 1, high in ISSUE or WAIT.
- drop, output, 1, sticky; a request arrived for an already-pending bit that was not being cleared that cycle.
- timeout_err, output, 1, sticky; WAIT exceeded TIMEOUT.

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; opcode=0, E=0, busy=0, pending=0, drop=0, timeout_err=0, rr pointer=0, timeout counter=0. Reset mid-ISSUE or mid-WAIT aborts immediately; requests present during reset are discarded.
- Pending update each cycle: pending_next = (pending & ~clr) | req.
  - clr is the one-hot of opcode on the accept cycle (E & ready), else 0.
  - A same-cycle req on the bit being cleared re-sets it (set wins).
  - drop sets if (req & pending & ~clr) != 0.
- FSM:
  - IDLE: if pending != 0, select index s, register opcode=s, go to ISSUE (E rises the next cycle). Requests arriving this cycle are not considered until the next selection.
  - ISSUE: E=1, opcode held stable. On ready=1: accept; clear pending[s]; if RR_EN, pointer=(s+1) mod 8. Then go to WAIT if MULTI_MASK[s], else IDLE. While ready=0, hold indefinitely; no re-arbitration.
  - WAIT: E=0, counter increments each cycle.
    - exec_done=1: go to IDLE and clear the counter.
    - Counter reaches TIMEOUT without exec_done: set timeout_err, go to IDLE.
    - exec_done in IDLE or ISSUE is ignored.
- Selection:
  - RR_EN=1: first set bit of pending scanning upward from pointer, wrapping 7->0.
  - RR_EN=0: lowest set index.
- Latency and throughput:
  - Request to E: 2 cycles minimum (req at cycle 0 registers into pending at edge 1; IDLE selects at edge 2; E high from cycle 2).
  - Single-cycle ops with ready tied high: one issue every 2 cycles.
- Outputs are registered and glitch-free. busy=1 exactly in ISSUE and WAIT.
- Reserved opcodes 5-7 are encoded and issued like any other; there is no filtering.

Test Plan:
- Reset then req=8'b0000_0001 for one cycle, ready=1 -> E high 1 cycle with opcode=0 at cycle 2; pending back to 0; busy low after.
- req=8'b0001_0011 in one cycle, RR_EN=1, ready=1 -> issue order 0, 1, 4; one E pulse per issue; each pending bit clears on its accept.
- RR_EN=0: hold req[0] high continuously while req[4] is pending -> opcode 0 issued repeatedly and 4 starves. Same stimulus with RR_EN=1 -> 0, 4, 0, 4 alternation.
- req=8'b0000_0100 (MUL), ready=1, exec_done 10 cycles after accept -> busy stays high in WAIT; next pending op issues only after exec_done; timeout_err=0.
- MUL with no exec_done -> after TIMEOUT=64 WAIT cycles: timeout_err=1 (sticky), FSM to IDLE, next request serviced.
- ready=0 held 5 cycles in ISSUE while req repeats the pending bit -> opcode stable, E high throughout, drop=1. Assert rst in that window -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/op_issue_encoder.sv
// op_issue_encoder: collects one-hot opcode requests into a pending vector and
// issues them one at a time as a 3-bit opcode with an enable strobe (E) under a
// valid/ready handshake. Multi-cycle opcodes hold the issuer in WAIT until
// exec_done, or until a timeout guard fires.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req[7:0]     request pulses, bit i requests opcode i
//   opcode[2:0]  encoded opcode (registered)
//   E            decoder enable / valid, high only while issuing
//   ready        downstream accepts when E & ready
//   exec_done    one-cycle pulse ending a multi-cycle op
//   pending[7:0] pending-request vector
//   busy         high while issuing or waiting
//   drop         sticky: request hit an already-pending bit not being cleared
//   timeout_err  sticky: WAIT ran out of cycles
module op_issue_encoder #(
    parameter bit          RR_EN      = 1'b1,
    parameter logic [7:0]  MULTI_MASK = 8'b0000_1100,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] opcode,
    output logic       E,
    input  logic       ready,
    input  logic       exec_done,
    output logic [7:0] pending,
    output logic       busy,
    output logic       drop,
    output logic       timeout_err
);

    localparam int unsigned N_OP  = 8;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic [OP_W-1:0]     opcode_q,  opcode_d;
    logic                e_q,       e_d;
    logic [N_OP-1:0]     pending_q, pending_d;
    logic                busy_q,    busy_d;
    logic                drop_q,    drop_d;
    logic                tmo_q,     tmo_d;
    logic [OP_W-1:0]     rr_ptr_q,  rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;

    logic                accept;
    logic [N_OP-1:0]     clr;
    logic                sel_found;
    logic [OP_W-1:0]     sel_idx;
    logic [OP_W-1:0]     cand;

    // Arbitration: scan upward from the pointer (round-robin) or from 0 (fixed).
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_OP; i++) begin
            cand = RR_EN ? (rr_ptr_q + OP_W'(i)) : OP_W'(i);
            if (!sel_found && pending_q[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Accept clears the issued bit; a same-cycle request on that bit re-sets it.
    always_comb begin
        accept = e_q & ready;
        clr    = '0;
        if (accept) begin
            clr[opcode_q] = 1'b1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        pending_d = (pending_q & ~clr) | req;
        drop_d    = drop_q | (|(req & pending_q & ~clr));

        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    opcode_d = sel_idx;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ready) begin
                    if (RR_EN) begin
                        rr_ptr_d = opcode_q + OP_W'(1);
                    end
                    cnt_d   = '0;
                    state_d = MULTI_MASK[opcode_q] ? ST_WAIT : ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (exec_done) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This cycle's increment would reach TIMEOUT: abort.
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        e_d    = (state_d == ST_ISSUE);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            e_q       <= 1'b0;
            pending_q <= '0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
            tmo_q     <= 1'b0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            e_q       <= e_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
            tmo_q     <= tmo_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign opcode      = opcode_q;
    assign E           = e_q;
    assign pending     = pending_q;
    assign busy        = busy_q;
    assign drop        = drop_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_op_issue_encoder.sv
// Testbench for op_issue_encoder: a round-robin and a fixed-priority instance
// share stimulus; both are compared every cycle against a behavioural model,
// plus a vector table and hand-written corner-case sequences.
module tb_op_issue_encoder;

    localparam int unsigned TMO   = 64;
    localparam logic [7:0]  MULTI = 8'b0000_1100;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ready;
    logic       exec_done;

    logic [2:0] rr_opcode, fp_opcode;
    logic       rr_e, fp_e;
    logic [7:0] rr_pending, fp_pending;
    logic       rr_busy, fp_busy;
    logic       rr_drop, fp_drop;
    logic       rr_tmo, fp_tmo;

    logic [14:0] rr_vec, fp_vec;
    assign rr_vec = {rr_opcode, rr_e, rr_pending, rr_busy, rr_drop, rr_tmo};
    assign fp_vec = {fp_opcode, fp_e, fp_pending, fp_busy, fp_drop, fp_tmo};

    op_issue_encoder #(.RR_EN(1'b1), .MULTI_MASK(MULTI), .TIMEOUT(TMO)) dut_rr (
        .clk(clk), .rst(rst), .req(req), .opcode(rr_opcode), .E(rr_e),
        .ready(ready), .exec_done(exec_done), .pending(rr_pending),
        .busy(rr_busy), .drop(rr_drop), .timeout_err(rr_tmo)
    );

    op_issue_encoder #(.RR_EN(1'b0), .MULTI_MASK(MULTI), .TIMEOUT(TMO)) dut_fp (
        .clk(clk), .rst(rst), .req(req), .opcode(fp_opcode), .E(fp_e),
        .ready(ready), .exec_done(exec_done), .pending(fp_pending),
        .busy(fp_busy), .drop(fp_drop), .timeout_err(fp_tmo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests;
    int n_fail;

    // Behavioural model, index 0 = round-robin instance, 1 = fixed priority.
    logic [7:0] m_pend[2];
    int         m_ptr[2];
    int         m_op[2];
    bit         m_iss[2];
    bit         m_wait[2];
    int         m_wcnt[2];
    bit         m_drop[2];
    bit         m_tmo[2];

    function automatic int pick(input logic [7:0] p, input int ptr, input bit rr);
        int idx;
        for (int off = 0; off < 8; off++) begin
            idx = rr ? (ptr + off) % 8 : off;
            if (p[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input int k, input bit rr);
        logic [7:0] clr;
        logic [7:0] npend;
        bit         idle;
        int         s;
        if (rst) begin
            m_pend[k] = '0; m_ptr[k] = 0; m_op[k] = 0; m_iss[k] = 0;
            m_wait[k] = 0;  m_wcnt[k] = 0; m_drop[k] = 0; m_tmo[k] = 0;
            return;
        end
        clr = '0;
        if (m_iss[k] && ready) clr[m_op[k]] = 1'b1;
        npend = (m_pend[k] & ~clr) | req;
        if ((req & m_pend[k] & ~clr) != 8'h00) m_drop[k] = 1;
        idle = !m_iss[k] && !m_wait[k];
        if (idle) begin
            s = pick(m_pend[k], m_ptr[k], rr);
            if (s >= 0) begin
                m_op[k]  = s;
                m_iss[k] = 1;
            end
        end else if (m_iss[k]) begin
            if (ready) begin
                if (rr) m_ptr[k] = (m_op[k] + 1) % 8;
                m_iss[k]  = 0;
                m_wait[k] = MULTI[m_op[k]];
                m_wcnt[k] = 0;
            end
        end else begin
            if (exec_done) begin
                m_wait[k] = 0;
                m_wcnt[k] = 0;
            end else begin
                m_wcnt[k]++;
                if (m_wcnt[k] == TMO) begin
                    m_tmo[k]  = 1;
                    m_wait[k] = 0;
                    m_wcnt[k] = 0;
                end
            end
        end
        m_pend[k] = npend;
    endtask

    function automatic logic [14:0] pack(input logic [2:0] op, input logic e,
                                         input logic [7:0] p, input logic b,
                                         input logic d, input logic t);
        return {op, e, p, b, d, t};
    endfunction

    function automatic logic [14:0] exp_vec(input int k);
        return pack(3'(m_op[k]), m_iss[k], m_pend[k], m_iss[k] | m_wait[k],
                    m_drop[k], m_tmo[k]);
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {op,E,pend,busy,drop,tmo}=%h want %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, step model at posedge, compare at next negedge.
    task automatic cycle(input logic [7:0] r, input logic rd, input logic dn, input logic rs);
        req = r; ready = rd; exec_done = dn; rst = rs;
        @(posedge clk);
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        @(negedge clk);
        check("model_rr", rr_vec, exp_vec(0));
        check("model_fp", fp_vec, exp_vec(1));
    endtask

    typedef struct {
        logic [7:0] req;
        logic       ready;
        logic       done;
        logic       rst;
        logic [2:0] op;
        logic       e;
        logic [7:0] pend;
        logic       busy;
    } vec_t;

    vec_t tbl[14];

    int rr_seq[$];
    int fp_seq[$];
    logic [7:0] r;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        req = '0; ready = 1'b0; exec_done = 1'b0; rst = 1'b1;

        // Single ADD, then burst {0,1,4} after a fresh reset.
        tbl[0]  = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h01, 1'b0};
        tbl[2]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h01, 1'b1};
        tbl[3]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[6]  = '{8'h13, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h13, 1'b0};
        tbl[7]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h13, 1'b1};
        tbl[8]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h12, 1'b0};
        tbl[9]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 8'h12, 1'b1};
        tbl[10] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 8'h10, 1'b0};
        tbl[11] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 8'h10, 1'b1};
        tbl[12] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 8'h00, 1'b0};
        tbl[13] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 8'h00, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].req, tbl[i].ready, tbl[i].done, tbl[i].rst);
            check($sformatf("tbl_rr[%0d]", i), rr_vec,
                  pack(tbl[i].op, tbl[i].e, tbl[i].pend, tbl[i].busy, 1'b0, 1'b0));
            check($sformatf("tbl_fp[%0d]", i), fp_vec,
                  pack(tbl[i].op, tbl[i].e, tbl[i].pend, tbl[i].busy, 1'b0, 1'b0));
        end

        // Starvation vs alternation with req 0 and 4 held continuously.
        cycle(8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cycle(8'h11, 1'b1, 1'b0, 1'b0);
            if (rr_e && rr_seq.size() < 6) rr_seq.push_back(int'(rr_opcode));
            if (fp_e && fp_seq.size() < 6) fp_seq.push_back(int'(fp_opcode));
        end
        check1("alt_rr_count", rr_seq.size(), 6);
        check1("starve_fp_count", fp_seq.size(), 6);
        for (int j = 0; j < rr_seq.size(); j++)
            check1($sformatf("alt_rr[%0d]", j), rr_seq[j], (j % 2 == 0) ? 0 : 4);
        for (int j = 0; j < fp_seq.size(); j++)
            check1($sformatf("starve_fp[%0d]", j), fp_seq[j], 0);
        check1("starve_drop", int'(rr_drop & fp_drop), 1);

        // MUL with exec_done 10 cycles after accept; ADD queued meanwhile.
        cycle(8'h00, 1'b1, 1'b0, 1'b1);
        cycle(8'h04, 1'b1, 1'b0, 1'b0);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        check1("mul_issue_op", int'(rr_opcode), 2);
        check1("mul_issue_e", int'(rr_e), 1);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 9; j++) begin
            check1("mul_wait_busy", int'(rr_busy), 1);
            check1("mul_wait_e", int'(rr_e), 0);
            cycle((j == 3) ? 8'h01 : 8'h00, 1'b1, 1'b0, 1'b0);
        end
        check1("mul_wait_busy_last", int'(rr_busy), 1);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        check1("mul_done_busy", int'(rr_busy), 0);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        check1("mul_next_e", int'(rr_e), 1);
        check1("mul_next_op", int'(rr_opcode), 0);
        check1("mul_no_tmo", int'(rr_tmo), 0);

        // MUL without exec_done: timeout after 64 WAIT cycles.
        cycle(8'h00, 1'b1, 1'b0, 1'b1);
        cycle(8'h04, 1'b1, 1'b0, 1'b0);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 63; j++) cycle(8'h00, 1'b1, 1'b0, 1'b0);
        check1("tmo_busy_63", int'(rr_busy), 1);
        check1("tmo_flag_63", int'(rr_tmo), 0);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        check1("tmo_busy_64", int'(rr_busy), 0);
        check1("tmo_flag_64", int'(rr_tmo), 1);
        cycle(8'h01, 1'b1, 1'b0, 1'b0);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        check1("tmo_next_e", int'(rr_e), 1);
        check1("tmo_next_op", int'(rr_opcode), 0);
        check1("tmo_sticky", int'(rr_tmo), 1);

        // Stall with ready low, repeated request sets drop, then reset mid-ISSUE.
        cycle(8'h00, 1'b0, 1'b0, 1'b1);
        cycle(8'h02, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            cycle(8'h02, 1'b0, 1'b0, 1'b0);
            check1("stall_e", int'(rr_e), 1);
            check1("stall_op", int'(rr_opcode), 1);
        end
        check1("stall_drop", int'(rr_drop), 1);
        cycle(8'h02, 1'b0, 1'b0, 1'b1);
        check("reset_mid_issue_rr", rr_vec, 15'h0000);
        check("reset_mid_issue_fp", fp_vec, 15'h0000);

        // Random traffic: frequent exec_done, then rare exec_done to hit timeouts.
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cycle(r,
                  1'($urandom_range(0, 3) != 0),
                  (i < 1500) ? 1'($urandom_range(0, 9) == 0)
                             : 1'($urandom_range(0, 149) == 0),
                  1'($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
